// File: rtl/bcd_pkg.sv
// Shared types, constants and the BCD digit to 7-segment pattern table for the
// display blocks.
package bcd_pkg;

   typedef enum logic {
      SHOW_ONES = 1'b0,
      SHOW_TENS = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   // Active-high pattern, bit0=a ... bit6=g; non-BCD codes show a dash.
   function automatic logic [6:0] seg7_pattern(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = SEG_DASH;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment decoder.
module bcd_to_seg7
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = seg7_pattern(digit);

endmodule

// File: rtl/bcd_2dig_seg_scan.sv
// Two-digit multiplexed 7-segment driver: shadows a tens/ones BCD pair and
// alternates the lit digit every SCAN_DIV cycles, with registered outputs.
module bcd_2dig_seg_scan
   import bcd_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter bit          LZ_BLANK       = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       err
);

   localparam int unsigned PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

   scan_state_t   state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    shadow_tens_q, shadow_ones_q;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          err_q, err_d;
   logic [3:0]    digit_mux;
   logic [6:0]    digit_seg;

   bcd_to_seg7 u_dec (
      .digit (digit_mux),
      .seg   (digit_seg)
   );

   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      an_d      = 2'b00;
      seg_d     = SEG_BLANK;
      digit_mux = (state_q == SHOW_TENS) ? shadow_tens_q : shadow_ones_q;
      err_d     = (shadow_tens_q > 4'd9) | (shadow_ones_q > 4'd9);

      if (en) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            state_d = (state_q == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
         end else begin
            presc_d = presc_q + PW'(1);
         end

         // Outputs follow the pre-edge state, so they lag the FSM by one cycle.
         if (state_q == SHOW_ONES) begin
            an_d  = 2'b01;
            seg_d = digit_seg;
         end else if (!(LZ_BLANK && shadow_tens_q == 4'd0)) begin
            an_d  = 2'b10;
            seg_d = digit_seg;
         end
      end

      if (SEG_ACTIVE_LOW) begin
         seg_d = ~seg_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= SHOW_ONES;
         presc_q       <= '0;
         shadow_tens_q <= 4'd0;
         shadow_ones_q <= 4'd0;
         seg_q         <= SEG_OFF;
         an_q          <= 2'b00;
         err_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         err_q   <= err_d;
         if (load) begin
            shadow_tens_q <= tens;
            shadow_ones_q <= ones;
         end
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign err = err_q;

endmodule

// File: tb/tb_bcd_2dig_seg_scan.sv
// Directed bench for bcd_2dig_seg_scan: default, no-blanking and active-low
// instances share one stimulus stream and are checked against fixed patterns.
module tb_bcd_2dig_seg_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       load;
   logic [3:0] tens;
   logic [3:0] ones;

   logic [6:0] seg, seg_nlz, seg_al;
   logic [1:0] an, an_nlz, an_al;
   logic       err, err_nlz, err_al;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bcd_2dig_seg_scan #(.SCAN_DIV(4), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut (
      .clk (clk), .rst (rst), .en (en), .load (load), .tens (tens), .ones (ones),
      .seg (seg), .an (an), .err (err)
   );

   bcd_2dig_seg_scan #(.SCAN_DIV(4), .LZ_BLANK(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_nlz (
      .clk (clk), .rst (rst), .en (en), .load (load), .tens (tens), .ones (ones),
      .seg (seg_nlz), .an (an_nlz), .err (err_nlz)
   );

   bcd_2dig_seg_scan #(.SCAN_DIV(4), .LZ_BLANK(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk (clk), .rst (rst), .en (en), .load (load), .tens (tens), .ones (ones),
      .seg (seg_al), .an (an_al), .err (err_al)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs n enabled-or-not edges, checking every instance after each one.
   task automatic run_slot(input string tag, input int n, input logic [1:0] an_e,
                           input logic [6:0] seg_e, input logic [6:0] seg_al_e,
                           input logic [1:0] an_nlz_e, input logic [6:0] seg_nlz_e,
                           input logic err_e);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, ".an"},      8'(an),      8'(an_e));
         check({tag, ".seg"},     8'(seg),     8'(seg_e));
         check({tag, ".seg_al"},  8'(seg_al),  8'(seg_al_e));
         check({tag, ".an_al"},   8'(an_al),   8'(an_e));
         check({tag, ".an_nlz"},  8'(an_nlz),  8'(an_nlz_e));
         check({tag, ".seg_nlz"}, 8'(seg_nlz), 8'(seg_nlz_e));
         check({tag, ".err"},     8'(err),     8'(err_e));
      end
   endtask

   // Captures a pair with the scan frozen so slot alignment is preserved.
   task automatic load_pair(input logic [3:0] t, input logic [3:0] o, input logic err_prev);
      en   = 1'b0;
      load = 1'b1;
      tens = t;
      ones = o;
      tick();
      load = 1'b0;
      check("load.an",  8'(an),     8'h00);
      check("load.seg", 8'(seg),    8'h00);
      check("load.err", 8'(err),    8'(err_prev));
      check("load.al",  8'(seg_al), 8'h7F);
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      tens = 4'd0;
      ones = 4'd0;
      #12;
      check("rst.an",      8'(an),      8'h00);
      check("rst.seg",     8'(seg),     8'h00);
      check("rst.err",     8'(err),     8'h00);
      check("rst.seg_al",  8'(seg_al),  8'h7F);
      check("rst.err_nlz", 8'(err_nlz), 8'h00);
      check("rst.err_al",  8'(err_al),  8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Basic scan, two full rounds.
      load_pair(4'd4, 4'd2, 1'b0);
      en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         run_slot("t1.ones", 4, 2'b01, 7'h5B, 7'h24, 2'b01, 7'h5B, 1'b0);
         run_slot("t1.tens", 4, 2'b10, 7'h66, 7'h19, 2'b10, 7'h66, 1'b0);
      end

      // Leading-zero blanking.
      load_pair(4'd0, 4'd7, 1'b0);
      en = 1'b1;
      run_slot("t2.ones", 4, 2'b01, 7'h07, 7'h78, 2'b01, 7'h07, 1'b0);
      run_slot("t2.tens", 4, 2'b00, 7'h00, 7'h7F, 2'b10, 7'h3F, 1'b0);

      // Invalid tens digit, then recovery.
      load_pair(4'hC, 4'd3, 1'b0);
      en = 1'b1;
      run_slot("t3.ones", 4, 2'b01, 7'h4F, 7'h30, 2'b01, 7'h4F, 1'b1);
      run_slot("t3.tens", 4, 2'b10, 7'h40, 7'h3F, 2'b10, 7'h40, 1'b1);
      load_pair(4'd1, 4'd3, 1'b1);
      en = 1'b1;
      run_slot("t3b.ones", 4, 2'b01, 7'h4F, 7'h30, 2'b01, 7'h4F, 1'b0);
      run_slot("t3b.tens", 4, 2'b10, 7'h06, 7'h79, 2'b10, 7'h06, 1'b0);

      // Active-low digit 8 plus an enable freeze mid ones slot.
      load_pair(4'd5, 4'd8, 1'b0);
      en = 1'b1;
      run_slot("t4.ones_a", 2,  2'b01, 7'h7F, 7'h00, 2'b01, 7'h7F, 1'b0);
      en = 1'b0;
      run_slot("t4.off",    10, 2'b00, 7'h00, 7'h7F, 2'b00, 7'h00, 1'b0);
      en = 1'b1;
      run_slot("t4.ones_b", 2,  2'b01, 7'h7F, 7'h00, 2'b01, 7'h7F, 1'b0);
      run_slot("t4.tens",   4,  2'b10, 7'h6D, 7'h12, 2'b10, 7'h6D, 1'b0);

      // Asynchronous reset mid tens slot.
      load_pair(4'hC, 4'd3, 1'b0);
      en = 1'b1;
      run_slot("t5.ones", 4, 2'b01, 7'h4F, 7'h30, 2'b01, 7'h4F, 1'b1);
      run_slot("t5.tens", 2, 2'b10, 7'h40, 7'h3F, 2'b10, 7'h40, 1'b1);
      #3;
      rst = 1'b1;
      #1;
      check("t5.rst.an",     8'(an),     8'h00);
      check("t5.rst.seg",    8'(seg),    8'h00);
      check("t5.rst.err",    8'(err),    8'h00);
      check("t5.rst.seg_al", 8'(seg_al), 8'h7F);
      check("t5.rst.an_nlz", 8'(an_nlz), 8'h00);
      @(negedge clk);
      rst = 1'b0;
      run_slot("t5.post.ones", 4, 2'b01, 7'h3F, 7'h40, 2'b01, 7'h3F, 1'b0);
      run_slot("t5.post.tens", 4, 2'b00, 7'h00, 7'h7F, 2'b10, 7'h3F, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
